// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: Decode fields, hazard controls and the staged control outputs.
// The control unit takes the slave side; the datapath and hazard logic take the master side.
interface pipelined_control_unit_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int IMM_SRC_W = 3
);
  logic [6:0] op_d;
  logic [2:0] funct3_d;
  logic [6:0] funct7_d;
  logic valid_d;
  logic stall_e;
  logic flush_e;
  logic flush_m;
  logic [IMM_SRC_W-1:0] imm_src_d;
  logic illegal_d;
  logic [ALU_CTRL_W-1:0] alu_control_e;
  logic alu_src_a_e;
  logic alu_src_b_e;
  logic branch_e;
  logic [2:0] branch_type_e;
  logic jump_e;
  logic jalr_e;
  logic valid_e;
  logic mem_write_m;
  logic mem_read_m;
  logic [1:0] result_src_m;
  logic reg_write_m;
  logic [1:0] result_src_w;
  logic reg_write_w;
  modport master (
    output op_d, funct3_d, funct7_d, valid_d, stall_e, flush_e, flush_m,
    input imm_src_d, illegal_d, alu_control_e, alu_src_a_e, alu_src_b_e, branch_e, branch_type_e,
    input jump_e, jalr_e, valid_e, mem_write_m, mem_read_m, result_src_m, reg_write_m,
    input result_src_w, reg_write_w
  );
  modport slave (
    input op_d, funct3_d, funct7_d, valid_d, stall_e, flush_e, flush_m,
    output imm_src_d, illegal_d, alu_control_e, alu_src_a_e, alu_src_b_e, branch_e, branch_type_e,
    output jump_e, jalr_e, valid_e, mem_write_m, mem_read_m, result_src_m, reg_write_m,
    output result_src_w, reg_write_w
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I decode with ID/EX, EX/MEM, MEM/WB control registers, stall/flush and illegal flagging.
// Define CU_MULDIV_EN to accept R-type funct7=0000001/funct3=000 as MUL; otherwise it is illegal.
module pipelined_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter int IMM_SRC_W = 3
) (
  input logic clk,
  input logic rst_n,
  pipelined_control_unit_if.slave cu
);
  typedef struct packed {
    logic [3:0] alu;
    logic src_a;
    logic src_b;
    logic branch;
    logic [2:0] branch_type;
    logic jump;
    logic jalr;
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic [1:0] result_src;
    logic valid;
  } ctrl_t;
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic [1:0] result_src;
  } mem_t;
  typedef struct packed {
    logic reg_write;
    logic [1:0] result_src;
  } wb_t;
  ctrl_t dec, ex;
  mem_t mem;
  wb_t wb;
  logic [6:0] op, f7;
  logic [2:0] f3, imm;
  logic bad, mul_ok;
  assign op = cu.op_d;
  assign f3 = cu.funct3_d;
  assign f7 = cu.funct7_d;
  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] alu_op(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000: return alt ? 4'b0001 : 4'b0000;
      3'b001: return 4'b0111;
      3'b010: return 4'b0101;
      3'b011: return 4'b0110;
      3'b100: return 4'b0100;
      3'b101: return alt ? 4'b1001 : 4'b1000;
      3'b110: return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction
`ifdef CU_MULDIV_EN
  assign mul_ok = f7 == 7'b0000001 && f3 == 3'b000;
`else
  assign mul_ok = 1'b0;
`endif
  always_comb begin
    dec = '0;
    imm = 3'b000;
    bad = 1'b0;
    dec.valid = 1'b1;
    case (op)
      7'b0000011: begin
        dec.src_b = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read = 1'b1;
        dec.result_src = 2'b01;
        bad = f3 != 3'b010;
      end
      7'b0100011: begin
        imm = 3'b001;
        dec.src_b = 1'b1;
        dec.mem_write = 1'b1;
        bad = f3 != 3'b010;
      end
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.alu = mul_ok ? 4'b1011 : alu_op(f3, f7[5]);
        bad = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) || mul_ok);
      end
      7'b0010011: begin
        dec.src_b = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu = alu_op(f3, f3 == 3'b101 && f7[5]);
        bad = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      7'b1100011: begin
        imm = 3'b010;
        dec.branch = 1'b1;
        dec.branch_type = f3;
        dec.alu = 4'b0001;
        bad = f3 == 3'b010 || f3 == 3'b011;
      end
      7'b1101111: begin
        imm = 3'b011;
        dec.jump = 1'b1;
        dec.reg_write = 1'b1;
        dec.result_src = 2'b10;
        dec.src_a = 1'b1;
        dec.src_b = 1'b1;
      end
      7'b1100111: begin
        dec.jalr = 1'b1;
        dec.reg_write = 1'b1;
        dec.result_src = 2'b10;
        dec.src_b = 1'b1;
      end
      7'b0110111: begin
        imm = 3'b100;
        dec.reg_write = 1'b1;
        dec.src_b = 1'b1;
        dec.alu = 4'b1010;
      end
      7'b0010111: begin
        imm = 3'b100;
        dec.reg_write = 1'b1;
        dec.src_a = 1'b1;
        dec.src_b = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end
  assign cu.illegal_d = cu.valid_d & bad;
  assign cu.imm_src_d = IMM_SRC_W'(imm);
  // Illegal or empty Decode slots enter ID/EX as the all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
    end else if (!cu.stall_e) begin
      ex <= (cu.flush_e || bad || !cu.valid_d) ? '0 : dec;
      mem <= cu.flush_m ? '0 : {ex.reg_write, ex.mem_write, ex.mem_read, ex.result_src};
      wb <= {mem.reg_write, mem.result_src};
    end
  end
  assign cu.alu_control_e = ALU_CTRL_W'(ex.alu);
  assign cu.alu_src_a_e = ex.src_a;
  assign cu.alu_src_b_e = ex.src_b;
  assign cu.branch_e = ex.branch;
  assign cu.branch_type_e = ex.branch_type;
  assign cu.jump_e = ex.jump;
  assign cu.jalr_e = ex.jalr;
  assign cu.valid_e = ex.valid;
  assign cu.mem_write_m = mem.mem_write;
  assign cu.mem_read_m = mem.mem_read;
  assign cu.result_src_m = mem.result_src;
  assign cu.reg_write_m = mem.reg_write;
  assign cu.result_src_w = wb.result_src;
  assign cu.reg_write_w = wb.reg_write;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed scenarios plus randomized stream against a table-driven reference pipeline.
module tb_pipelined_control_unit;
  typedef struct packed {
    logic [3:0] alu;
    logic a, b, br;
    logic [2:0] bt;
    logic j, jr, rw, mw, mr;
    logic [1:0] rs;
    logic v;
  } ref_t;
  localparam logic [31:0] ALU_TBL = {4'b0010, 4'b0011, 4'b1000, 4'b0100, 4'b0110, 4'b0101, 4'b0111, 4'b0000};
`ifdef CU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int pass = 0;
  int total = 0;
  ref_t pipe [3];
  pipelined_control_unit_if bus ();
  pipelined_control_unit dut (.clk(clk), .rst_n(rst_n), .cu(bus));
  always #5 clk = ~clk;

  function automatic ref_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                      output logic ill, output logic [2:0] imm);
    ref_t r;
    logic ld, st, rr, ia, br, jl, jr, lu, au, mul, alt;
    ld = op == 7'h03; st = op == 7'h23; rr = op == 7'h33; ia = op == 7'h13; br = op == 7'h63;
    jl = op == 7'h6f; jr = op == 7'h67; lu = op == 7'h37; au = op == 7'h17;
    mul = MULDIV && rr && f7 == 7'h01 && f3 == 3'd0;
    alt = (rr && f7 == 7'h20) || (ia && f3 == 3'd5 && f7[5]);
    ill = !(ld || st || rr || ia || br || jl || jr || lu || au)
       || ((ld || st) && f3 != 3'd2)
       || (br && (f3 == 3'd2 || f3 == 3'd3))
       || (rr && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || mul))
       || (ia && f3 == 3'd1 && f7 != 7'h00)
       || (ia && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
    imm = st ? 3'd1 : br ? 3'd2 : jl ? 3'd3 : (lu || au) ? 3'd4 : 3'd0;
    r = '0;
    r.v = 1'b1;
    r.rw = ld || rr || ia || jl || jr || lu || au;
    r.mw = st;
    r.mr = ld;
    r.rs = ld ? 2'b01 : (jl || jr) ? 2'b10 : 2'b00;
    r.a = jl || au;
    r.b = ld || st || ia || jl || jr || lu || au;
    r.br = br;
    r.bt = br ? f3 : 3'd0;
    r.j = jl;
    r.jr = jr;
    r.alu = mul ? 4'b1011 : lu ? 4'b1010 : br ? 4'b0001 :
            (rr || ia) ? ALU_TBL[f3*4 +: 4] + {3'b0, alt && (f3 == 3'd0 || f3 == 3'd5)} : 4'b0000;
    return r;
  endfunction

  function automatic logic [12:0] dut_e();
    return {bus.alu_control_e[3:0], bus.alu_src_a_e, bus.alu_src_b_e, bus.branch_e, bus.branch_type_e,
            bus.jump_e, bus.jalr_e, bus.valid_e};
  endfunction
  function automatic logic [4:0] dut_m();
    return {bus.mem_write_m, bus.mem_read_m, bus.result_src_m, bus.reg_write_m};
  endfunction
  function automatic logic [2:0] dut_w();
    return {bus.result_src_w, bus.reg_write_w};
  endfunction
  function automatic logic [12:0] exp_e();
    return {pipe[0].alu, pipe[0].a, pipe[0].b, pipe[0].br, pipe[0].bt, pipe[0].j, pipe[0].jr, pipe[0].v};
  endfunction
  function automatic logic [4:0] exp_m();
    return {pipe[1].mw, pipe[1].mr, pipe[1].rs, pipe[1].rw};
  endfunction
  function automatic logic [2:0] exp_w();
    return {pipe[2].rs, pipe[2].rw};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic v, input logic st, input logic fe, input logic fm);
    bus.op_d = op; bus.funct3_d = f3; bus.funct7_d = f7; bus.valid_d = v;
    bus.stall_e = st; bus.flush_e = fe; bus.flush_m = fm;
  endtask

  task automatic tick();
    ref_t d;
    logic ill;
    logic [2:0] imm;
    d = ref_decode(bus.op_d, bus.funct3_d, bus.funct7_d, ill, imm);
    @(posedge clk);
    if (!rst_n) pipe = '{default: '0};
    else if (!bus.stall_e) begin
      pipe[2] = pipe[1];
      pipe[1] = bus.flush_m ? '0 : pipe[0];
      pipe[0] = (bus.flush_e || ill || !bus.valid_d) ? '0 : d;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(7'h00, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    tick(); tick();
    total++; if ({dut_e(), dut_m(), dut_w()} !== 21'd0) $display("FAIL reset_init: got %h want 0", {dut_e(), dut_m(), dut_w()}); else pass++;
    #3 rst_n = 1'b1;
    drive(7'h23, 3'd2, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(7'h33, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (bus.mem_write_m !== 1'b1) $display("FAIL reset_sw_in_m: got %b want 1", bus.mem_write_m); else pass++;
    #2 rst_n = 1'b0;
    pipe = '{default: '0};
    #1;
    total++; if ({dut_e(), dut_m(), dut_w()} !== 21'd0) $display("FAIL reset_async: got %h want 0", {dut_e(), dut_m(), dut_w()}); else pass++;
    #1 rst_n = 1'b1;
    drive(7'h00, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if ({dut_e(), dut_m(), dut_w()} !== 21'd0) $display("FAIL reset_after_release: got %h want 0", {dut_e(), dut_m(), dut_w()}); else pass++;
  endtask

  task automatic test_alu_stream();
    logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h20};
    logic [2:0] f3s [3] = '{3'd0, 3'd0, 3'd5};
    logic [3:0] alus [3] = '{4'b0000, 4'b0001, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      drive(7'h33, f3s[i], f7s[i], 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      total++; if (bus.alu_control_e !== alus[i]) $display("FAIL alu_stream_%0d: got %b want %b", i, bus.alu_control_e, alus[i]); else pass++;
    end
    total++; if (bus.reg_write_w !== 1'b1) $display("FAIL stream_wb_add: got %b want 1", bus.reg_write_w); else pass++;
    drive(7'h00, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.reg_write_w !== (i < 2)) $display("FAIL stream_wb_%0d: got %b want %b", i, bus.reg_write_w, i < 2); else pass++;
    end
  endtask

  task automatic test_stall_load();
    drive(7'h00, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    drive(7'h03, 3'd2, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (bus.valid_e !== 1'b1) $display("FAIL lw_in_e: got %b want 1", bus.valid_e); else pass++;
    drive(7'h00, 3'd0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.mem_read_m !== 1'b0 || bus.valid_e !== 1'b1) $display("FAIL lw_stall_%0d: got mr=%b ve=%b want mr=0 ve=1", i, bus.mem_read_m, bus.valid_e); else pass++;
    end
    bus.stall_e = 1'b0;
    tick();
    total++; if (bus.mem_read_m !== 1'b1 || bus.result_src_m !== 2'b01 || bus.result_src_w !== 2'b00) $display("FAIL lw_in_m: got mr=%b rs=%b rsw=%b want 1 01 00", bus.mem_read_m, bus.result_src_m, bus.result_src_w); else pass++;
    tick();
    total++; if (bus.result_src_w !== 2'b01 || bus.reg_write_w !== 1'b1) $display("FAIL lw_in_w: got rs=%b rw=%b want 01 1", bus.result_src_w, bus.reg_write_w); else pass++;
  endtask

  task automatic test_flush_branch();
    drive(7'h63, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if ({bus.branch_e, bus.branch_type_e, bus.alu_control_e} !== {1'b1, 3'd0, 4'b0001}) $display("FAIL beq_in_e: got %b want 10000001", {bus.branch_e, bus.branch_type_e, bus.alu_control_e}); else pass++;
    drive(7'h33, 3'd0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (dut_e() !== 13'd0) $display("FAIL flush_e_bubble: got %h want 0", dut_e()); else pass++;
    drive(7'h00, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (bus.reg_write_m !== 1'b0) $display("FAIL flush_m_later: got %b want 0", bus.reg_write_m); else pass++;
  endtask

  task automatic test_illegal();
    logic [16:0] bad_tbl [7] = '{{7'h7f, 3'd0, 7'h00}, {7'h03, 3'd0, 7'h00}, {7'h63, 3'd2, 7'h00},
                                 {7'h13, 3'd1, 7'h20}, {7'h33, 3'd0, 7'h40}, {7'h33, 3'd1, 7'h20},
                                 {7'h13, 3'd5, 7'h40}};
    for (int i = 0; i < 7; i++) begin
      drive(bad_tbl[i][16:10], bad_tbl[i][9:7], bad_tbl[i][6:0], 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (bus.illegal_d !== 1'b1) $display("FAIL illegal_d_%0d: got %b want 1", i, bus.illegal_d); else pass++;
      tick();
      total++; if (dut_e() !== 13'd0) $display("FAIL illegal_bubble_%0d: got %h want 0", i, dut_e()); else pass++;
    end
    drive(7'h7f, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (bus.illegal_d !== 1'b0) $display("FAIL illegal_needs_valid: got %b want 0", bus.illegal_d); else pass++;
    drive(7'h13, 3'd5, 7'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (bus.illegal_d !== 1'b0) $display("FAIL srai_legal: got %b want 0", bus.illegal_d); else pass++;
    tick();
    total++; if (bus.alu_control_e !== 4'b1001) $display("FAIL srai_alu: got %b want 1001", bus.alu_control_e); else pass++;
  endtask

  task automatic test_muldiv();
    drive(7'h33, 3'd0, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (bus.illegal_d !== !MULDIV) $display("FAIL mul_illegal: got %b want %b", bus.illegal_d, !MULDIV); else pass++;
    tick();
    total++; if ({bus.alu_control_e, bus.valid_e} !== (MULDIV ? 5'b10111 : 5'b00000)) $display("FAIL mul_in_e: got %b want %b", {bus.alu_control_e, bus.valid_e}, MULDIV ? 5'b10111 : 5'b00000); else pass++;
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h00};
    logic [6:0] op, f7;
    logic [2:0] f3, imm;
    logic v, ill;
    ref_t d;
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) op = 7'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      v = $urandom_range(0, 7) != 0;
      drive(op, f3, f7, v, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      #1;
      d = ref_decode(op, f3, f7, ill, imm);
      total++; if (bus.illegal_d !== (v && ill)) $display("FAIL rnd_illegal_%0d: got %b want %b", i, bus.illegal_d, v && ill); else pass++;
      if (!ill) begin
        total++; if (bus.imm_src_d !== imm) $display("FAIL rnd_imm_%0d: got %b want %b", i, bus.imm_src_d, imm); else pass++;
      end
      tick();
      total++; if (dut_e() !== exp_e()) $display("FAIL rnd_e_%0d: got %h want %h", i, dut_e(), exp_e()); else pass++;
      total++; if (dut_m() !== exp_m()) $display("FAIL rnd_m_%0d: got %h want %h", i, dut_m(), exp_m()); else pass++;
      total++; if (dut_w() !== exp_w()) $display("FAIL rnd_w_%0d: got %h want %h", i, dut_w(), exp_w()); else pass++;
    end
  endtask

  initial begin
    pipe = '{default: '0};
    test_reset();
    test_alu_stream();
    test_stall_load();
    test_flush_branch();
    test_illegal();
    test_muldiv();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
